// File: rtl/store_buffer.sv
// Word store buffer between a single-cycle core and a slower external write bus.
// Stores are queued in a small FIFO and drained over a req/ack handshake.
module store_buffer #(
    parameter  int DEPTH = 4,
    parameter  int AW    = 32,
    parameter  int DW    = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_write,
    input  logic [AW-1:0] alu_result,
    input  logic [DW-1:0] write_data,
    input  logic [1:0]    result_src,
    output logic          stall,
    output logic          bus_req,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    output logic [CW-1:0] count,
    output logic          misalign_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          aligned;
    logic          full;
    logic          push;
    logic          pop;

    assign aligned = (alu_result[1:0] == 2'b00);
    // Fullness uses the pre-edge count, so a same-edge pop never frees a slot for a push.
    assign full    = (count == CW'(DEPTH));
    assign push    = mem_write & aligned & ~full;
    assign pop     = (state == REQ) & bus_ack;

    assign stall = (mem_write & aligned & full)
                 | ((result_src == 2'b01) & ~mem_write & (count != '0));

    assign bus_req   = (state == REQ);
    assign bus_addr  = addr_mem[rd_ptr];
    assign bus_wdata = data_mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (count != '0) state_next = REQ;
            REQ:  if (pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (mem_write && !aligned) misalign_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= alu_result;
            data_mem[wr_ptr] <= write_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected bus writes go into a scoreboard queue,
// a negedge monitor pops and compares whenever the bus accepts a write.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_write = 1'b0;
    logic [AW-1:0] alu_result = '0;
    logic [DW-1:0] write_data = '0;
    logic [1:0]    result_src = 2'b00;
    logic          stall;
    logic          bus_req;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack = 1'b0;
    logic [CW-1:0] count;
    logic          misalign_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int max_c     = 0;
    logic [AW+DW-1:0] sb_q [$];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_write    (mem_write),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .result_src   (result_src),
        .stall        (stall),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .count        (count),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the store until the buffer takes it; queues the expected bus write on acceptance.
    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 0;
        mem_write  = 1'b1;
        alu_result = a;
        write_data = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1;
        end
        if (!done) check("store_timeout", 64'(stall), 64'd0);
        else sb_q.push_back({a, d});
        tick();
        mem_write = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (count == '0) done = 1;
        end
        check(name, 64'(count), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus_req && bus_ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_bus_write", {bus_addr, bus_wdata}, 64'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = sb_q.pop_front();
                check("bus_write", {bus_addr, bus_wdata}, e);
            end
        end
        if (int'(count) > max_c) max_c = int'(count);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic exp_stall [3];
        logic [CW-1:0] exp_cnt [3];

        // reset state
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        tick();
        reset = 1'b0;

        // 1: reset mid-drain
        bus_ack = 1'b0;
        do_store(32'h10, 32'h1111_0000);
        do_store(32'h14, 32'h1111_0001);
        do_store(32'h18, 32'h1111_0002);
        @(negedge clk);
        check("t1_req_before_rst", 64'(bus_req), 64'd1);
        check("t1_count_before_rst", 64'(count), 64'd3);
        #2 reset = 1'b1;
        #1;
        check("t1_req_async_drop", 64'(bus_req), 64'd0);
        check("t1_count_async_clear", 64'(count), 64'd0);
        tick();
        reset = 1'b0;
        sb_q.delete();
        bus_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t1_no_req_after_rst", 64'(bus_req), 64'd0);
        end
        tick();

        // 2: single store, latency
        do_store(32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t2_cyc1_req", 64'(bus_req), 64'd0);
        check("t2_cyc1_count", 64'(count), 64'd1);
        tick();
        @(negedge clk);
        check("t2_cyc2_req", 64'(bus_req), 64'd1);
        check("t2_cyc2_addr", 64'(bus_addr), 64'h100);
        check("t2_cyc2_data", 64'(bus_wdata), 64'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check("t2_cyc3_count", 64'(count), 64'd0);
        check("t2_cyc3_req", 64'(bus_req), 64'd0);
        tick();

        // 3: fill and stall
        bus_ack = 1'b0;
        for (int i = 0; i < 4; i++) do_store(32'h200 + 32'(4 * i), 32'h3000 + 32'(i));
        mem_write  = 1'b1;
        alu_result = 32'h210;
        write_data = 32'h3004;
        @(negedge clk);
        check("t3_stall_full", 64'(stall), 64'd1);
        check("t3_count_full", 64'(count), 64'd4);
        tick();
        bus_ack = 1'b1;
        @(negedge clk);
        check("t3_stall_pop_edge", 64'(stall), 64'd1);
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        check("t3_count_after_pop", 64'(count), 64'd3);
        check("t3_stall_released", 64'(stall), 64'd0);
        tick();
        mem_write = 1'b0;
        sb_q.push_back({32'h210, 32'h3004});
        @(negedge clk);
        check("t3_count_refill", 64'(count), 64'd4);
        tick();
        bus_ack = 1'b1;
        wait_empty("t3_drain");
        tick();

        // 4: wrap-around with toggling ack
        max_c = 0;
        bus_ack = 1'b0;
        fork
            for (int i = 0; i < 40; i++) begin
                tick();
                bus_ack = ~bus_ack;
            end
            for (int j = 0; j < 10; j++) do_store(32'(4 * j), 32'hA000_0000 + 32'(j));
        join
        bus_ack = 1'b1;
        wait_empty("t4_drain");
        check("t4_max_count", 64'(max_c <= DEPTH), 64'd1);
        check("t4_all_observed", 64'(sb_q.size()), 64'd0);
        tick();

        // 5: load ordering
        bus_ack = 1'b0;
        do_store(32'h300, 32'h5555_0000);
        do_store(32'h304, 32'h5555_0001);
        result_src = 2'b01;
        bus_ack = 1'b1;
        exp_stall[0] = 1'b1; exp_cnt[0] = 3'd2;
        exp_stall[1] = 1'b1; exp_cnt[1] = 3'd1;
        exp_stall[2] = 1'b0; exp_cnt[2] = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_load_stall", 64'(stall), 64'(exp_stall[i]));
            check("t5_load_count", 64'(count), 64'(exp_cnt[i]));
        end
        tick();
        result_src = 2'b00;

        // 6: misaligned store
        mem_write  = 1'b1;
        alu_result = 32'h102;
        write_data = 32'h6666_6666;
        @(negedge clk);
        check("t6_no_stall", 64'(stall), 64'd0);
        check("t6_err_before", 64'(misalign_err), 64'd0);
        tick();
        mem_write = 1'b0;
        @(negedge clk);
        check("t6_err_set", 64'(misalign_err), 64'd1);
        check("t6_count", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t6_no_req", 64'(bus_req), 64'd0);
        end
        check("t6_err_sticky", 64'(misalign_err), 64'd1);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
